// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if -- handshake bundle between fetch, the fetch buffer and rename.
//   enq_valid/enq_ready/enq_pc/enq_instr : fetch -> buffer
//   deq_valid/deq_ready/deq_pc/deq_instr : buffer -> rename
// Modports:
//   slave  : the buffer
//   master : the fetch/rename environment driving it
interface fetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;

  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr
  );

  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer -- in-order instruction buffer between fetch and rename.
// Absorbs fetch bursts, presents one {pc, instr} per cycle to rename, and
// squashes every buffered entry in one cycle on a mispredict flush.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-low reset (overrides flush/handshakes)
//   flush     : mispredict squash, clears pointers and blocks handshakes
//   bus       : fetch_buffer_if.slave (enq_* from fetch, deq_* to rename)
//   count     : current occupancy
//   flush_cnt : saturating count of flush cycles since reset
// Optional feature: define FETCH_BUFFER_BYPASS_EN to let an instruction pass
// combinationally from enq to deq when the buffer is empty.
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  fetch_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         flush_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            full, empty;
  logic            bypass;
  logic            enq_fire, deq_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign empty = (head == tail);
  assign count = tail - head;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = empty && bus.enq_valid && bus.deq_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.enq_ready = !full && !flush;
  assign bus.deq_valid = (!empty || bypass) && !flush;
  assign bus.deq_pc    = bypass ? bus.enq_pc    : mem_pc[head[AW-1:0]];
  assign bus.deq_instr = bypass ? bus.enq_instr : mem_instr[head[AW-1:0]];

  // A bypassed instruction is handed straight to rename, so neither pointer moves.
  assign enq_fire = bus.enq_valid && bus.enq_ready && !bypass;
  assign deq_fire = bus.deq_valid && bus.deq_ready && !bypass;

  // Storage is never cleared; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_pc[tail[AW-1:0]]    <= bus.enq_pc;
      mem_instr[tail[AW-1:0]] <= bus.enq_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      if (flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + 1'b1;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]       flush_cnt;

  fetch_buffer_if #(.XLEN(XLEN)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .count(count), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // Reference model: an ordered queue of {pc, instr}, plus a flush counter.
  logic [63:0] mq[$];
  logic [CNT_W-1:0] mfc = '0;

  always @(posedge clk) begin
    bit byp, do_enq, do_deq;
    if (!reset) begin
      mq.delete();
      mfc = '0;
    end else if (flush) begin
      mq.delete();
      if (mfc != {CNT_W{1'b1}}) mfc = mfc + 1'b1;
    end else begin
      byp = BYP && mq.size() == 0 && bus.enq_valid && bus.deq_ready;
      if (!byp) begin
        do_deq = bus.deq_ready && mq.size() > 0;
        do_enq = bus.enq_valid && mq.size() < DEPTH;
        if (do_deq) void'(mq.pop_front());
        if (do_enq) mq.push_back({bus.enq_pc, bus.enq_instr});
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    bit byp, ev;
    logic [63:0] head;
    if (chk_en) begin
      byp = BYP && mq.size() == 0 && bus.enq_valid && bus.deq_ready && !flush;
      ev  = !flush && (mq.size() > 0 || byp);
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_flush_cnt", 64'(flush_cnt), 64'(mfc));
      check("m_enq_ready", 64'(bus.enq_ready), 64'(!flush && mq.size() < DEPTH));
      check("m_deq_valid", 64'(bus.deq_valid), 64'(ev));
      if (ev && bus.deq_valid) begin
        head = byp ? {bus.enq_pc, bus.enq_instr} : mq[0];
        check("m_deq_data", {bus.deq_pc, bus.deq_instr}, head);
      end
    end
  end

  task automatic drive(input logic rst, input logic fl, input logic ev,
                       input logic [31:0] pc, input logic dr);
    reset         = rst;
    flush         = fl;
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_instr = instr_of(pc);
    bus.deq_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    // Reset held 2 cycles with enq_valid high
    tick(); tick();
    @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    tick();

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    @(negedge clk);
    check("full_count", 64'(count), 64'd8);
    check("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    tick();
    check("ninth_refused", 64'(count), 64'd8);
    // Full refuses enqueue even with a concurrent dequeue
    drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
    @(negedge clk);
    check("full_deq_pc0", 64'(bus.deq_pc), 64'h0);
    tick();
    check("full_enq_deq_count", 64'(count), 64'd7);
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("drain_pc", 64'(bus.deq_pc), 64'(4 * i));
      tick();
    end
    check("drained_count", 64'(count), 64'd0);

    // Wrap-around: preload 3, then 20 cycles of enqueue+dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h200 + 32'(4 * (k + 3)), 1'b1);
      @(negedge clk);
      check("wrap_pc", 64'(bus.deq_pc), 64'h200 + 64'(4 * k));
      tick();
      check("wrap_count", 64'(count), 64'd3);
    end
    for (int k = 20; k < 23; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("wrap_tail_pc", 64'(bus.deq_pc), 64'h200 + 64'(4 * k));
      tick();
    end
    check("wrap_empty", 64'(count), 64'd0);

    // Mispredict flush with 5 buffered and pc 0x40 offered in the flush cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h300 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    @(negedge clk);
    check("flush_enq_blocked", 64'(bus.enq_ready), 64'd0);
    check("flush_deq_blocked", 64'(bus.deq_valid), 64'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("post_flush_count", 64'(count), 64'd0);
    check("post_flush_valid", 64'(bus.deq_valid), 64'd0);
    check("post_flush_cnt", 64'(flush_cnt), 64'd1);
    check("post_flush_ready", 64'(bus.enq_ready), 64'd1);
    tick(); tick();
    check("no_0x40", 64'(bus.deq_valid), 64'd0);

    // Bypass / one-cycle latency from empty
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    @(negedge clk);
    if (BYP) begin
      check("byp_valid", 64'(bus.deq_valid), 64'd1);
      check("byp_pc", 64'(bus.deq_pc), 64'h100);
      check("byp_count", 64'(count), 64'd0);
      tick();
      check("byp_count_after", 64'(count), 64'd0);
    end else begin
      check("nobyp_valid0", 64'(bus.deq_valid), 64'd0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("nobyp_valid1", 64'(bus.deq_valid), 64'd1);
      check("nobyp_pc", 64'(bus.deq_pc), 64'h100);
      check("nobyp_count", 64'(count), 64'd1);
      tick();
      check("nobyp_count_after", 64'(count), 64'd0);
    end

    // Reset versus flush with 4 buffered
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    check("pre_rst_count", 64'(count), 64'd4);
    drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rvf_count", 64'(count), 64'd0);
    check("rvf_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rvf_valid", 64'(bus.deq_valid), 64'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
